// File: rtl/torv_fetch_buf_if.sv
// Fetch-buffer bus bundle: imem request/response, execute redirect, decode handshake, occupancy.
// Latency: none, wiring only.
// Backpressure: decode stalls through out_ready; the buffer throttles fetch through imem_en.
interface torv_fetch_buf_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic [31:0]   out_ir;
    logic [AW-1:0] out_pc;
    logic          out_pred;
    logic          out_ready;
    logic [CW-1:0] count;

    // Fetch-buffer side.
    modport master (
        output imem_en, imem_addr, out_valid, out_ir, out_pc, out_pred, count,
        input  imem_data, redirect, redirect_addr, out_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_en, imem_addr, out_valid, out_ir, out_pc, out_pred, count,
        output imem_data, redirect, redirect_addr, out_ready
    );
endinterface

// File: rtl/torv_fetch_buf.sv
// Instruction fetch front end: owns fetch PC, drives sync imem, queues {PC,IR} for decode.
// Latency: fetch issued in cycle N is pushed in N+1 and visible at the queue head in N+2.
// Backpressure: credit check on next occupancy stops fetch so the queue never overflows.
// Optional FBUF_JAL_PREDICT_EN: predict JAL taken at push time and redirect fetch locally.
module torv_fetch_buf #(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             resetn,
    torv_fetch_buf_if.master bus
);
    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW:0]   DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] ALIGN_MASK = ~{{(AW-2){1'b0}}, 2'b11};
    localparam logic [AW-1:0] PC_STEP    = AW'(4);
    localparam logic [6:0]    OPC_JAL    = 7'b1101111;

    logic [AW-1:0] f_pc_q, f_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic          resp_valid_q, resp_valid_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   ir_q [DEPTH];
    logic [AW-1:0] pc_q [DEPTH];

    logic          head_vld;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   next_occ;
    logic          jal_hit;
    logic          pred_taken;
    logic [AW-1:0] jal_imm;
    logic [AW-1:0] jal_target;

    // JAL decode on the word arriving from memory; constant-off when prediction is not built.
    always_comb begin
        jal_hit = 1'b0;
        jal_imm = '0;
`ifdef FBUF_JAL_PREDICT_EN
        jal_hit = resp_valid_q && (bus.imem_data[6:0] == OPC_JAL);
        jal_imm = {{(AW-20){bus.imem_data[31]}}, bus.imem_data[19:12], bus.imem_data[20],
                   bus.imem_data[30:21], 1'b0};
`endif
        jal_target = resp_pc_q + jal_imm;
        // External redirect outranks a local prediction.
        pred_taken = jal_hit && !bus.redirect;
    end

    // Handshake, credit check and next-state for PC, pointers and occupancy.
    always_comb begin
        head_vld     = (count_q != '0);
        pop          = head_vld && bus.out_ready;
        push         = resp_valid_q && !bus.redirect;
        // Occupancy after this edge if nothing new were issued; the in-flight word needs a slot.
        next_occ     = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, resp_valid_q};
        issue        = resetn && !bus.redirect && !pred_taken && (next_occ < DEPTH_W);

        f_pc_d       = f_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = issue;
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        wr_ptr_d     = wr_ptr_q + PW'(push);
        count_d      = count_q + CW'(push) - CW'(pop);

        if (issue) begin
            f_pc_d    = f_pc_q + PC_STEP;
            resp_pc_d = f_pc_q;
        end

        if (bus.redirect) begin
            f_pc_d   = bus.redirect_addr & ALIGN_MASK;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (pred_taken) begin
            f_pc_d   = jal_target & ALIGN_MASK;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_pc_q       <= RESET_PC & ALIGN_MASK;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            f_pc_q       <= f_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Queue payload storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_q[wr_ptr_q] <= bus.imem_data;
            pc_q[wr_ptr_q] <= resp_pc_q;
        end
    end

`ifdef FBUF_JAL_PREDICT_EN
    logic [DEPTH-1:0] pred_q;

    // Prediction flag per entry, written alongside the payload.
    always_ff @(posedge clk) begin
        if (push) begin
            pred_q[wr_ptr_q] <= jal_hit;
        end
    end

    assign bus.out_pred = head_vld && pred_q[rd_ptr_q];
`else
    assign bus.out_pred = 1'b0;
`endif

    assign bus.imem_en   = issue;
    assign bus.imem_addr = f_pc_q & ALIGN_MASK;
    assign bus.out_valid = head_vld;
    assign bus.out_ir    = head_vld ? ir_q[rd_ptr_q] : 32'h0;
    assign bus.out_pc    = head_vld ? pc_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_torv_fetch_buf.sv
// Bench for torv_fetch_buf: sync memory model, PC model and {PC,IR,pred} scoreboard.
// Latency: checks first fetch in cycle 0 and first output in cycle 2 after reset release.
// Backpressure: exercises decode stall, redirect, async reset, PC wrap and JAL.
module tb_torv_fetch_buf;
    localparam int          DEPTH    = 4;
    localparam int          AW       = 32;
    localparam logic [31:0] JAL_WORD = 32'h0400_006F;  // jal x0, +0x40
`ifdef FBUF_JAL_PREDICT_EN
    localparam bit PRED_ON = 1'b1;
`else
    localparam bit PRED_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        pred;
    } exp_t;

    logic clk;
    logic resetn;
    exp_t sb[$];
    logic [31:0] model_pc;
    logic [31:0] prev_out_pc;
    logic [31:0] after_jal_pc;
    logic        wrap_seen;
    int n_chk;
    int n_fail;
    int n_issue;
    int n_out;

    torv_fetch_buf_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    torv_fetch_buf #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20) return JAL_WORD;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory: data valid the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= mem_word(bus.imem_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic flush_model(input logic [31:0] pc);
        sb.delete();
        model_pc    = pc;
        prev_out_pc = 32'h1;
    endtask

    // One cycle: drive inputs after negedge, score outputs, advance to next negedge.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] raddr);
        exp_t e;
        bus.out_ready     = rdy;
        bus.redirect      = redir;
        bus.redirect_addr = raddr;
        #1;
        check_val("count_le_depth", 32'(bus.count <= DEPTH), 32'd1);
        if (bus.out_valid && rdy) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                check_val("out_pc", bus.out_pc, e.pc);
                check_val("out_ir", bus.out_ir, e.ir);
                check_val("out_pred", 32'(bus.out_pred), 32'(e.pred));
                if (prev_out_pc == 32'hFFFF_FFFC && bus.out_pc == 32'h0) wrap_seen = 1'b1;
                if (prev_out_pc == 32'h20) after_jal_pc = bus.out_pc;
                prev_out_pc = bus.out_pc;
                n_out++;
            end
        end
        if (redir) begin
            check_val("imem_en_on_redirect", 32'(bus.imem_en), 32'd0);
            flush_model({raddr[31:2], 2'b00});
        end else if (bus.imem_en) begin
            check_val("imem_addr", bus.imem_addr, model_pc);
            e.pc   = model_pc;
            e.ir   = mem_word(model_pc);
            e.pred = PRED_ON && (e.ir == JAL_WORD);
            sb.push_back(e);
            n_issue++;
            model_pc = e.pred ? model_pc + 32'h40 : model_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic sync_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush_model(32'h0);
        resetn = 1'b1;
    endtask

    initial begin
        int base;
        clk = 1'b0;
        resetn = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.imem_data = '0;
        n_chk = 0; n_fail = 0; n_issue = 0; n_out = 0;
        wrap_seen = 1'b0;
        after_jal_pc = '0;
        flush_model(32'h0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("rst_imem_en", 32'(bus.imem_en), 32'd0);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_count", 32'(bus.count), 32'd0);
        check_val("rst_out_pred", 32'(bus.out_pred), 32'd0);
        check_val("rst_out_pc", bus.out_pc, 32'd0);
        check_val("rst_out_ir", bus.out_ir, 32'd0);
        @(negedge clk);

        // Release with decode ready: fetch in cycle 0, output from cycle 2, 1 instr/cycle
        resetn = 1'b1;
        #1;
        check_val("first_imem_en", 32'(bus.imem_en), 32'd1);
        check_val("first_imem_addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (i == 1) check_val("cyc1_out_valid", 32'(bus.out_valid), 32'd0);
            if (i == 2) check_val("cyc2_out_pc", bus.out_pc, 32'h0);
            if (i >= 2 && i <= 8) check_val("throughput_valid", 32'(bus.out_valid), 32'd1);
            step(1'b1, 1'b0, '0);
        end

        // Stall one cycle to reach count=2, then assert reset mid-cycle
        step(1'b0, 1'b0, '0);
        #1;
        check_val("pre_reset_count", 32'(bus.count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check_val("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("async_rst_imem_en", 32'(bus.imem_en), 32'd0);
        check_val("async_rst_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        flush_model(32'h0);
        resetn = 1'b1;
        #1;
        check_val("restart_addr", bus.imem_addr, 32'h0);

        // Decode stalled 10 cycles: exactly DEPTH fetches, saturate, then drain in order
        base = n_issue;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check_val("stall_fetches", n_issue - base, 32'd4);
        check_val("stall_count", 32'(bus.count), 32'd4);
        check_val("stall_no_fetch", 32'(bus.imem_en), 32'd0);
        base = n_out;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        check_val("drain_outputs", n_out - base, 32'd5);

        // Redirect with count=3 and a response in flight
        sync_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        #1;
        check_val("pre_redirect_count", 32'(bus.count), 32'd3);
        step(1'b0, 1'b1, 32'h103);
        bus.redirect = 1'b0;
        #1;
        check_val("post_redirect_count", 32'(bus.count), 32'd0);
        check_val("post_redirect_valid", 32'(bus.out_valid), 32'd0);
        check_val("post_redirect_en", 32'(bus.imem_en), 32'd1);
        check_val("post_redirect_addr", bus.imem_addr, 32'h100);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // PC wrap-around at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        check_val("pc_wrap_order", 32'(wrap_seen), 32'd1);

        // JAL at 0x20: predicted jump to 0x60 when built in, else sequential 0x24
        after_jal_pc = '0;
        step(1'b1, 1'b1, 32'h18);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        check_val("after_jal_pc", after_jal_pc, PRED_ON ? 32'h60 : 32'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
